rmst_to_fifo_tile: RTL and testbench

//  Load-side stage that pairs with the store-side write-master tile. Splits an iolen-word region at

---
 rtl/rmst_to_fifo_tile_if.sv | 49 ++++
 rtl/rmst_to_fifo_tile.sv | 172 +++++++++++++++++
 tb/tb_rmst_to_fifo_tile.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rmst_to_fifo_tile_if.sv
// Avalon read-master user port plus compute-FIFO push port.
// The master modport is the tile side; the slave modport is the environment side.
interface rmst_to_fifo_tile_if #(
  parameter int CW  = 6,
  parameter int DW  = 32,
  parameter int XAW = 32,
  parameter int XDW = 128,
  parameter int FW  = 9
);
  logic           rmst_fixed_location;
  logic [XAW-1:0] rmst_read_base;
  logic [CW-1:0]  rmst_read_length;
  logic           rmst_go;
  logic           rmst_done;
  logic [XDW-1:0] rmst_user_read_data;
  logic           rmst_user_data_available;
  logic           rmst_user_read_buffer;
  logic           fifo_push;
  logic [DW-1:0]  fifo_data_in;
  logic [FW-1:0]  fifo_free;

  modport master (
    output rmst_fixed_location,
    output rmst_read_base,
    output rmst_read_length,
    output rmst_go,
    input  rmst_done,
    input  rmst_user_read_data,
    input  rmst_user_data_available,
    output rmst_user_read_buffer,
    output fifo_push,
    output fifo_data_in,
    input  fifo_free
  );

  modport slave (
    input  rmst_fixed_location,
    input  rmst_read_base,
    input  rmst_read_length,
    input  rmst_go,
    output rmst_done,
    output rmst_user_read_data,
    output rmst_user_data_available,
    input  rmst_user_read_buffer,
    input  fifo_push,
    input  fifo_data_in,
    output fifo_free
  );
endinterface

// File: rtl/rmst_to_fifo_tile.sv
// Load stage: bursts a region through the Avalon read master into the compute FIFO.
// Define RMST_ENDIAN_SWAP_EN to byte-reverse every pushed word.
module rmst_to_fifo_tile #(
  parameter int AW   = 12,
  parameter int CW   = 6,
  parameter int DW   = 32,
  parameter int XAW  = 32,
  parameter int XDW  = 128,
  parameter int BLEN = 8,
  parameter int FW   = 9
) (
  input  logic            clk,
  input  logic            rst,
  rmst_to_fifo_tile_if.master bus,
  input  logic            config_done,
  input  logic [AW-1:0]   param_iolen,
  input  logic [XAW-1:0]  param_raddr,
  input  logic            load_data_start,
  output logic            load_data_done
);

  localparam int WCNT = XDW / DW;
  localparam int LW   = $clog2(WCNT + 1);
  localparam int CMPW = ((AW > FW) ? AW : FW) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WLOW, S_WHIGH, S_DRAIN, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  iolen_q, iolen_d;
  logic [XAW-1:0] raddr_q, raddr_d;
  logic [XAW-1:0] addr_q, addr_d;
  logic [AW-1:0]  req_q, req_d;
  logic [AW-1:0]  reqd_q, reqd_d;
  logic [AW-1:0]  pcnt_q, pcnt_d;
  logic [LW-1:0]  lanes_q, lanes_d;
  logic [XDW-1:0] unpk_q, unpk_d;
  logic           push_q, push_d;
  logic [DW-1:0]  wdata_q, wdata_d;

  logic           go, ack, busy, room;
  logic [AW-1:0]  blen, inflight, eff_iolen;
  logic [XAW-1:0] eff_raddr;

  function automatic logic [DW-1:0] fmt(input logic [DW-1:0] w);
    logic [DW-1:0] r;
`ifdef RMST_ENDIAN_SWAP_EN
    for (int b = 0; b < DW/8; b++)
      r[8*b +: 8] = w[DW-8-8*b +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  assign blen      = (req_q < AW'(BLEN)) ? req_q : AW'(BLEN);
  assign inflight  = reqd_q - pcnt_q;
  assign room      = CMPW'(bus.fifo_free) >= (CMPW'(inflight) + CMPW'(blen));
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign ack       = busy && bus.rmst_user_data_available &&
                     (lanes_q == LW'(0) || lanes_q == LW'(1));
  assign eff_iolen = config_done ? param_iolen : iolen_q;
  assign eff_raddr = config_done ? param_raddr : raddr_q;

  always_comb begin
    state_d = state_q;
    iolen_d = iolen_q;
    raddr_d = raddr_q;
    addr_d  = addr_q;
    req_d   = req_q;
    reqd_d  = reqd_q;
    pcnt_d  = pcnt_q;
    lanes_d = lanes_q;
    unpk_d  = unpk_q;
    push_d  = 1'b0;
    wdata_d = wdata_q;
    go      = 1'b0;

    // Drain one lane per cycle; lanes past iolen are dropped.
    if (busy && lanes_q != LW'(0)) begin
      lanes_d = lanes_q - LW'(1);
      unpk_d  = unpk_q >> DW;
      if (pcnt_q < iolen_q) begin
        push_d  = 1'b1;
        wdata_d = fmt(unpk_q[DW-1:0]);
        pcnt_d  = pcnt_q + AW'(1);
      end
    end
    if (ack) begin
      unpk_d  = bus.rmst_user_read_data;
      lanes_d = LW'(WCNT);
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        lanes_d = '0;
        if (config_done) begin
          iolen_d = param_iolen;
          raddr_d = param_raddr;
          state_d = S_IDLE;
        end
        if (load_data_start) begin
          addr_d  = eff_raddr;
          req_d   = eff_iolen;
          reqd_d  = '0;
          pcnt_d  = '0;
          state_d = (eff_iolen == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.rmst_done && room) begin
          go      = 1'b1;
          addr_d  = addr_q + XAW'({blen, 2'b00});
          req_d   = req_q - blen;
          reqd_d  = reqd_q + blen;
          state_d = S_WLOW;
        end
      end
      S_WLOW: begin
        if (!bus.rmst_done) state_d = S_WHIGH;
      end
      S_WHIGH: begin
        if (bus.rmst_done)
          state_d = (req_q != '0) ? S_ISSUE : S_DRAIN;
      end
      S_DRAIN: begin
        if (pcnt_q == iolen_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      iolen_q <= '0;
      raddr_q <= '0;
      addr_q  <= '0;
      req_q   <= '0;
      reqd_q  <= '0;
      pcnt_q  <= '0;
      lanes_q <= '0;
      unpk_q  <= '0;
      push_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      iolen_q <= iolen_d;
      raddr_q <= raddr_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      reqd_q  <= reqd_d;
      pcnt_q  <= pcnt_d;
      lanes_q <= lanes_d;
      unpk_q  <= unpk_d;
      push_q  <= push_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.rmst_fixed_location   = 1'b0;
  assign bus.rmst_go               = go;
  assign bus.rmst_read_base        = addr_q;
  assign bus.rmst_read_length      =
    (state_q == S_ISSUE) ? CW'({blen, 2'b00}) : '0;
  assign bus.rmst_user_read_buffer = ack;
  assign bus.fifo_push             = push_q;
  assign bus.fifo_data_in          = wdata_q;
  assign load_data_done            = (state_q == S_DONE);

endmodule

// File: tb/tb_rmst_to_fifo_tile.sv
// Directed bench: a behavioural read master feeds the tile; a scoreboard
// checks every burst request and every FIFO word against queued expectations.
module tb_rmst_to_fifo_tile;

  logic        clk = 1'b0;
  logic        rst;
  logic        config_done;
  logic [11:0] param_iolen;
  logic [31:0] param_raddr;
  logic        load_data_start;
  logic        load_data_done;

  always #5 clk = ~clk;

  rmst_to_fifo_tile_if bus ();

  rmst_to_fifo_tile dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .config_done     (config_done),
    .param_iolen     (param_iolen),
    .param_raddr     (param_raddr),
    .load_data_start (load_data_start),
    .load_data_done  (load_data_done)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0]  exp_q[$];
  logic [63:0]  go_q[$];
  logic [127:0] beat_q[$];
  logic [127:0] bt;
  logic [63:0]  ge;
  logic [31:0]  base_f, len_f;
  logic [31:0]  first_word;
  bit           go_f, ack_f, toggle, phase, first_seen;
  int           go_cnt, ack_cnt, push_cnt;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h2000) return 32'h11223344;
    return {8'hA5, a[23:0]};
  endfunction

  function automatic logic [31:0] expw(input logic [31:0] w);
`ifdef RMST_ENDIAN_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural read master
  always @(negedge clk) begin
    go_f   = bus.rmst_go;
    base_f = bus.rmst_read_base;
    len_f  = 32'(bus.rmst_read_length);
    ack_f  = bus.rmst_user_read_buffer && bus.rmst_user_data_available;
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      beat_q.delete();
      bus.rmst_done = 1'b1;
      phase = 1'b0;
    end else begin
      if (ack_f && beat_q.size() > 0) begin
        void'(beat_q.pop_front());
        ack_cnt++;
      end
      if (go_f) begin
        for (int k = 0; k < (len_f + 15) / 16; k++) begin
          for (int l = 0; l < 4; l++)
            bt[32*l +: 32] = mem(base_f + 32'(16*k + 4*l));
          beat_q.push_back(bt);
        end
        bus.rmst_done = 1'b0;
        go_cnt++;
      end else if (beat_q.size() == 0) begin
        bus.rmst_done = 1'b1;
      end
      phase = ~phase;
    end
    bus.rmst_user_data_available = (beat_q.size() > 0) && (!toggle || phase);
    bus.rmst_user_read_data = (beat_q.size() > 0) ? beat_q[0] : '0;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rmst_go) begin
        check("go_expected", 64'(go_q.size() != 0), 64'd1);
        if (go_q.size() != 0) begin
          ge = go_q.pop_front();
          check("go_base", 64'(bus.rmst_read_base), 64'(ge[63:32]));
          check("go_len", 64'(bus.rmst_read_length), 64'(ge[31:0]));
        end
      end
      if (bus.fifo_push) begin
        push_cnt++;
        check("push_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0)
          check("push_data", 64'(bus.fifo_data_in), 64'(exp_q.pop_front()));
        if (!first_seen) begin
          first_word = bus.fifo_data_in;
          first_seen = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_words(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++)
      exp_q.push_back(expw(mem(a + 32'(4*i))));
    go_cnt = 0; ack_cnt = 0; push_cnt = 0; first_seen = 1'b0;
  endtask

  task automatic setup(input int n, input logic [31:0] a);
    param_iolen = 12'(n);
    param_raddr = a;
    config_done = 1'b1;
    tick(1);
    config_done = 1'b0;
    check("cfg_clears_done", 64'(load_data_done), 64'd0);
    expect_words(n, a);
  endtask

  task automatic start();
    load_data_start = 1'b1;
    tick(1);
    load_data_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int n);
    int k;
    k = 0;
    while (!load_data_done && k < 500) begin
      tick(1);
      k++;
    end
    check({nm, "_done"}, 64'(load_data_done), 64'd1);
    tick(3);
    check({nm, "_pushes"}, 64'(push_cnt), 64'(n));
    check({nm, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    check({nm, "_go_left"}, 64'(go_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    config_done = 1'b0;
    load_data_start = 1'b0;
    param_iolen = '0;
    param_raddr = '0;
    toggle = 1'b0;
    bus.rmst_done = 1'b1;
    bus.rmst_user_data_available = 1'b0;
    bus.rmst_user_read_data = '0;
    bus.fifo_free = 9'd256;
    tick(3);
    check("rst_go", 64'(bus.rmst_go), 64'd0);
    check("rst_ack", 64'(bus.rmst_user_read_buffer), 64'd0);
    check("rst_push", 64'(bus.fifo_push), 64'd0);
    check("rst_done", 64'(load_data_done), 64'd0);
    check("rst_base", 64'(bus.rmst_read_base), 64'd0);
    check("rst_len", 64'(bus.rmst_read_length), 64'd0);
    check("rst_fixed", 64'(bus.rmst_fixed_location), 64'd0);
    rst = 1'b0;
    tick(1);

    // two full bursts
    setup(16, 32'h1000);
    go_q.push_back({32'h1000, 32'd32});
    go_q.push_back({32'h1020, 32'd32});
    start();
    wait_done("t16", 16);
    check("t16_gos", 64'(go_cnt), 64'd2);

    // partial final beat
    setup(10, 32'h3000);
    go_q.push_back({32'h3000, 32'd32});
    go_q.push_back({32'h3020, 32'd8});
    start();
    wait_done("t10", 10);
    check("t10_acks", 64'(ack_cnt), 64'd3);

    // credit gating
    bus.fifo_free = 9'd4;
    setup(8, 32'h4000);
    go_q.push_back({32'h4000, 32'd32});
    start();
    tick(20);
    check("lowfree_nogo", 64'(go_cnt), 64'd0);
    bus.fifo_free = 9'd8;
    wait_done("credit", 8);
    check("credit_gos", 64'(go_cnt), 64'd1);
    bus.fifo_free = 9'd256;

    // toggling availability
    toggle = 1'b1;
    setup(16, 32'h5000);
    go_q.push_back({32'h5000, 32'd32});
    go_q.push_back({32'h5020, 32'd32});
    start();
    wait_done("toggle", 16);
    toggle = 1'b0;

    // reset while waiting on the master
    setup(16, 32'h6000);
    go_q.push_back({32'h6000, 32'd32});
    go_q.push_back({32'h6020, 32'd32});
    start();
    begin
      int k;
      k = 0;
      while (go_cnt == 0 && k < 100) begin
        tick(1);
        k++;
      end
      check("rst_mid_go_seen", 64'(go_cnt), 64'd1);
    end
    tick(1);
    rst = 1'b1;
    tick(1);
    check("rstmid_go", 64'(bus.rmst_go), 64'd0);
    check("rstmid_ack", 64'(bus.rmst_user_read_buffer), 64'd0);
    check("rstmid_push", 64'(bus.fifo_push), 64'd0);
    check("rstmid_done", 64'(load_data_done), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    go_q.delete();
    tick(1);
    setup(16, 32'h6000);
    go_q.push_back({32'h6000, 32'd32});
    go_q.push_back({32'h6020, 32'd32});
    start();
    wait_done("rerun", 16);

    // byte order of a known word
    setup(4, 32'h2000);
    go_q.push_back({32'h2000, 32'd16});
    start();
    wait_done("swap", 4);
`ifdef RMST_ENDIAN_SWAP_EN
    check("swap_word", 64'(first_word), 64'h44332211);
`else
    check("swap_word", 64'(first_word), 64'h11223344);
`endif

    // restart from DONE with retained parameters
    expect_words(4, 32'h2000);
    go_q.push_back({32'h2000, 32'd16});
    start();
    wait_done("restart", 4);

    // empty transfer
    setup(0, 32'h7000);
    start();
    check("zero_done", 64'(load_data_done), 64'd1);
    tick(5);
    check("zero_gos", 64'(go_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
